psg_bus_writer: RTL and testbench

PSG_BUS_WRITER -- requirements
Module: psg_bus_writer

---
 rtl/psg_bus_writer.sv | 108 ++++++++++
 tb/tb_psg_bus_writer.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/psg_bus_writer.sv
// Bus-side register file of an SN76489-style PSG: decodes latch/data bytes
// written on the rising edge of we into tone periods, attenuations and noise control.
module psg_bus_writer #(
    parameter logic [3:0] RESET_ATTENUATION = 4'd15
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] data,
    input  logic       we,
    output logic [9:0] tone_freq0,
    output logic [9:0] tone_freq1,
    output logic [9:0] tone_freq2,
    output logic [3:0] attn0,
    output logic [3:0] attn1,
    output logic [3:0] attn2,
    output logic [3:0] attn3,
    output logic [2:0] noise_control,
    output logic       restart_noise
);

    logic       we_prev_q;
    logic [2:0] latch_q, latch_d;
    logic [9:0] tone_q [3];
    logic [9:0] tone_d [3];
    logic [3:0] attn_q [4];
    logic [3:0] attn_d [4];
    logic [2:0] noise_q, noise_d;
    logic       noise_wr_q, noise_wr_d;
    logic       restart_q;

    logic       accept;
    logic [2:0] target;
    logic [1:0] ch;

    assign accept = we & ~we_prev_q;

    always_comb begin
        latch_d    = latch_q;
        tone_d     = tone_q;
        attn_d     = attn_q;
        noise_d    = noise_q;
        noise_wr_d = 1'b0;
        target     = latch_q;
        ch         = latch_q[2:1];

        if (accept) begin
            // A latch byte both retargets and writes, so decode it against its own {channel,type}.
            if (data[7]) begin
                latch_d = data[6:4];
                target  = data[6:4];
            end
            ch = target[2:1];

            if (target[0]) begin
                attn_d[ch] = data[3:0];
            end else if (ch == 2'd3) begin
                noise_d    = data[2:0];
                noise_wr_d = 1'b1;
            end else begin
                for (int unsigned i = 0; i < 3; i++) begin
                    if (ch == 2'(i)) begin
                        if (data[7]) begin
                            tone_d[i][3:0] = data[3:0];
                        end else begin
                            tone_d[i][9:4] = data[5:0];
                        end
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            // we_prev_q starts high so a we already asserted at release is not a write.
            we_prev_q  <= 1'b1;
            latch_q    <= '0;
            for (int unsigned i = 0; i < 3; i++) begin
                tone_q[i] <= '0;
            end
            for (int unsigned i = 0; i < 4; i++) begin
                attn_q[i] <= RESET_ATTENUATION;
            end
            noise_q    <= '0;
            noise_wr_q <= 1'b0;
            restart_q  <= 1'b0;
        end else begin
            we_prev_q  <= we;
            latch_q    <= latch_d;
            tone_q     <= tone_d;
            attn_q     <= attn_d;
            noise_q    <= noise_d;
            noise_wr_q <= noise_wr_d;
            restart_q  <= noise_wr_q;
        end
    end

    assign tone_freq0    = tone_q[0];
    assign tone_freq1    = tone_q[1];
    assign tone_freq2    = tone_q[2];
    assign attn0         = attn_q[0];
    assign attn1         = attn_q[1];
    assign attn2         = attn_q[2];
    assign attn3         = attn_q[3];
    assign noise_control = noise_q;
    assign restart_noise = restart_q;

endmodule

// File: tb/tb_psg_bus_writer.sv
// Self-checking bench for psg_bus_writer: directed scenarios plus random byte
// streams compared each cycle against a behavioural register-file model.
module tb_psg_bus_writer;

    localparam logic [3:0] RST_ATT = 4'd15;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] data = '0;
    logic       we = 1'b0;
    logic [9:0] tone_freq0, tone_freq1, tone_freq2;
    logic [3:0] attn0, attn1, attn2, attn3;
    logic [2:0] noise_control;
    logic       restart_noise;

    int errors = 0;
    int checks = 0;

    // Reference model state
    int m_tone [3];
    int m_attn [4];
    int m_noise;
    int m_lch, m_ltype;
    bit m_prev_we;
    bit m_pend;
    bit m_restart;

    psg_bus_writer #(.RESET_ATTENUATION(RST_ATT)) dut (
        .clk          (clk),
        .reset        (reset),
        .data         (data),
        .we           (we),
        .tone_freq0   (tone_freq0),
        .tone_freq1   (tone_freq1),
        .tone_freq2   (tone_freq2),
        .attn0        (attn0),
        .attn1        (attn1),
        .attn2        (attn2),
        .attn3        (attn3),
        .noise_control(noise_control),
        .restart_noise(restart_noise)
    );

    always #5 clk = ~clk;

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 3; i++) m_tone[i] = 0;
        for (int i = 0; i < 4; i++) m_attn[i] = RST_ATT;
        m_noise   = 0;
        m_lch     = 0;
        m_ltype   = 0;
        m_prev_we = 1'b1;
        m_pend    = 1'b0;
        m_restart = 1'b0;
    endtask

    // Register-file semantics of one accepted bus byte
    task automatic model_write(input int d);
        if (d >= 128) begin
            m_lch   = (d / 32) % 4;
            m_ltype = (d / 16) % 2;
        end
        if (m_ltype == 1) begin
            m_attn[m_lch] = d % 16;
        end else if (m_lch == 3) begin
            m_noise = d % 8;
            m_pend  = 1'b1;
        end else if (d >= 128) begin
            m_tone[m_lch] = (m_tone[m_lch] / 16) * 16 + (d % 16);
        end else begin
            m_tone[m_lch] = (d % 64) * 16 + (m_tone[m_lch] % 16);
        end
    endtask

    task automatic check_all(input string tag);
        check_eq({tag, ".tone0"}, 32'(tone_freq0), 32'(m_tone[0]));
        check_eq({tag, ".tone1"}, 32'(tone_freq1), 32'(m_tone[1]));
        check_eq({tag, ".tone2"}, 32'(tone_freq2), 32'(m_tone[2]));
        check_eq({tag, ".attn0"}, 32'(attn0), 32'(m_attn[0]));
        check_eq({tag, ".attn1"}, 32'(attn1), 32'(m_attn[1]));
        check_eq({tag, ".attn2"}, 32'(attn2), 32'(m_attn[2]));
        check_eq({tag, ".attn3"}, 32'(attn3), 32'(m_attn[3]));
        check_eq({tag, ".noise"}, 32'(noise_control), 32'(m_noise));
        check_eq({tag, ".restart"}, 32'(restart_noise), 32'(m_restart));
    endtask

    // One clock: drive at negedge, advance model at posedge, compare just after.
    task automatic cycle(input string tag, input logic r, input logic w, input logic [7:0] d);
        @(negedge clk);
        reset = r;
        we    = w;
        data  = d;
        @(posedge clk);
        #1;
        if (r) begin
            model_reset();
        end else begin
            m_restart = m_pend;
            m_pend    = 1'b0;
            if (w && !m_prev_we) model_write(int'(d));
            m_prev_we = w;
        end
        check_all(tag);
    endtask

    task automatic write_byte(input string tag, input logic [7:0] d, input int hold, input int gap);
        cycle(tag, 1'b0, 1'b1, d);
        for (int h = 1; h < hold; h++) cycle(tag, 1'b0, 1'b1, 8'($urandom));
        for (int g = 0; g < gap; g++) cycle(tag, 1'b0, 1'b0, 8'($urandom));
    endtask

    task automatic do_reset(input string tag);
        cycle(tag, 1'b1, 1'b0, 8'h00);
        cycle(tag, 1'b1, 1'b0, 8'h00);
        cycle(tag, 1'b0, 1'b0, 8'h00);
    endtask

    initial begin
        model_reset();
        do_reset("reset");

        // Data byte with no prior latch targets tone 0 high bits
        write_byte("r032", 8'h15, 1, 2);
        check_eq("r032.tone0", 32'(tone_freq0), 32'h150);
        check_eq("r032.attn0", 32'(attn0), 32'(RST_ATT));

        do_reset("reset2");
        write_byte("r029a", 8'h8A, 1, 1);
        write_byte("r029b", 8'h3F, 1, 2);
        check_eq("r029.tone0", 32'(tone_freq0), 32'h3FA);

        // Noise latch: value after one edge, pulse on the following edge only
        cycle("r030", 1'b0, 1'b1, 8'hE5);
        check_eq("r030.noise", 32'(noise_control), 32'h5);
        check_eq("r030.rst_lo", 32'(restart_noise), 32'h0);
        cycle("r030", 1'b0, 1'b0, 8'h00);
        check_eq("r030.rst_hi", 32'(restart_noise), 32'h1);
        cycle("r030", 1'b0, 1'b0, 8'h00);
        check_eq("r030.rst_end", 32'(restart_noise), 32'h0);

        // Held strobe: one write only
        cycle("r031", 1'b0, 1'b1, 8'hD3);
        for (int i = 0; i < 5; i++) cycle("r031", 1'b0, 1'b1, 8'h07);
        cycle("r031", 1'b0, 1'b0, 8'h07);
        check_eq("r031.attn2", 32'(attn2), 32'h3);

        write_byte("r033a", 8'hA0, 1, 1);
        write_byte("r033b", 8'h01, 2, 1);
        check_eq("r033.tone1a", 32'(tone_freq1), 32'h010);
        write_byte("r033c", 8'h02, 1, 1);
        check_eq("r033.tone1b", 32'(tone_freq1), 32'h020);

        // Noise writes two cycles apart give two distinct pulses
        write_byte("r023a", 8'hE1, 1, 1);
        write_byte("r023b", 8'h06, 1, 3);

        for (int n = 0; n < 300; n++) begin
            write_byte("rand", 8'($urandom), int'($urandom_range(1, 3)), int'($urandom_range(1, 2)));
        end

        // Async reset in the middle of a restart pulse with we still high
        cycle("r034", 1'b0, 1'b1, 8'hE5);
        cycle("r034", 1'b0, 1'b1, 8'hE5);
        check_eq("r034.pulse", 32'(restart_noise), 32'h1);
        #2;
        reset = 1'b1;
        #1;
        model_reset();
        check_all("r034.async");
        cycle("r034.hold", 1'b1, 1'b1, 8'h8F);
        cycle("r034.rel", 1'b0, 1'b1, 8'h8F);
        cycle("r034.rel", 1'b0, 1'b1, 8'h8F);
        check_eq("r034.noacc", 32'(tone_freq0), 32'h0);
        cycle("r034.low", 1'b0, 1'b0, 8'h8F);
        write_byte("r034.wr", 8'h8F, 1, 1);
        check_eq("r034.acc", 32'(tone_freq0), 32'h00F);

        for (int n = 0; n < 100; n++) begin
            write_byte("rand2", 8'($urandom), int'($urandom_range(1, 2)), int'($urandom_range(1, 2)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
